// File: rtl/serial_bit_source_pkg.sv
// serial_bit_source_pkg: shared types and constants for the serializer feeding the 1101 detector
package serial_bit_source_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_DATA_W   = 8;
    localparam bit          DEFAULT_IDLE_BIT = 1'b0;
    localparam logic [3:0]  DETECT_PATTERN   = 4'b1101;

endpackage

// File: rtl/serial_bit_source.sv
// serial_bit_source: valid/ready word loader that streams words one bit per clock with no inter-word gap
module serial_bit_source
    import serial_bit_source_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ser_out_q, ser_out_d;
    logic              ser_valid_q, ser_valid_d;
    logic              ser_last_q, ser_last_d;
    logic              take;
    logic              shifting;
    logic [DATA_W-1:0] src_w;

    assign load_ready = !reset && (state_q == IDLE || ser_last_q);
    assign take       = load_valid && load_ready;
    assign shifting   = take || (state_q == SHIFT && !ser_last_q);
    assign src_w      = take ? load_data : shift_q;
    assign ser_out    = ser_out_q;
    assign ser_valid  = ser_valid_q;
    assign ser_last   = ser_last_q;
    assign busy       = state_q == SHIFT;

    // Next state: shift_q holds the bits not yet presented, so the bit moving onto ser_out comes from src_w
    always_comb begin
        state_d     = IDLE;
        bit_cnt_d   = '0;
        shift_d     = shift_q;
        ser_out_d   = IDLE_BIT;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        if (shifting) begin
            state_d     = SHIFT;
            bit_cnt_d   = take ? '0 : bit_cnt_q + CNT_W'(1);
            shift_d     = MSB_FIRST ? src_w << 1 : src_w >> 1;
            ser_out_d   = MSB_FIRST ? src_w[DATA_W-1] : src_w[0];
            ser_valid_d = 1'b1;
            ser_last_d  = bit_cnt_d == LAST_CNT;
        end
    end

    // State and output registers; reset drops any in-flight or offered word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            ser_out_q   <= IDLE_BIT;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: MSB-first and LSB-first serializers checked against a pending-bit-list model
module tb_serial_bit_source;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic [1:0] rdy, so, sv, sl, bz;

    int checks;
    int failures;

    bit   qa[2][8];
    int   qn[2];
    logic eo[2];
    logic ev[2];
    logic el[2];

    serial_bit_source #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy[0]), .ser_out(so[0]), .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0])
    );

    serial_bit_source #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .load_data(load_data), .load_valid(load_valid),
        .load_ready(rdy[1]), .ser_out(so[1]), .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // One clock: drive inputs, check ready, advance the model across the edge, check registered outputs.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        logic [1:0] er;
        reset = r;
        load_valid = v;
        load_data = d;
        #1;
        for (int c = 0; c < 2; c++) begin
            er[c] = !r && qn[c] == 0;
            chk($sformatf("load_ready[%0d]", c), rdy[c], er[c]);
        end
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                qn[c] = 0;
            end else if (v && er[c]) begin
                for (int i = 0; i < 8; i++) qa[c][i] = (c == 0) ? d[7-i] : d[i];
                qn[c] = 8;
            end
            if (!r && qn[c] > 0) begin
                eo[c] = qa[c][0];
                for (int i = 0; i < 7; i++) qa[c][i] = qa[c][i+1];
                qn[c]--;
                ev[c] = 1'b1;
                el[c] = qn[c] == 0;
            end else begin
                eo[c] = 1'b0;
                ev[c] = 1'b0;
                el[c] = 1'b0;
            end
        end
        #1;
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("ser_out[%0d]", c), so[c], eo[c]);
            chk($sformatf("ser_valid[%0d]", c), sv[c], ev[c]);
            chk($sformatf("ser_last[%0d]", c), sl[c], el[c]);
            chk($sformatf("busy[%0d]", c), bz[c], ev[c]);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        qn[0] = 0;
        qn[1] = 0;
        reset = 1'b1;
        load_valid = 1'b0;
        load_data = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hFF);
        // single word D0 then idle
        step(1'b0, 1'b1, 8'hD0);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'($urandom));
        // back-to-back D0 then A5 with load_valid held high
        step(1'b0, 1'b1, 8'hD0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hA5);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);
        // 0B: 1101 when sent LSB first
        step(1'b0, 1'b1, 8'h0B);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);
        // reset on bit 3 of FF, then 81
        step(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h81);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 8'h00);
        // toggling data during 5A must not be accepted
        step(1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, (i % 2) ? 8'hFF : 8'h00);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'hFF);
        // reset and handshake on the same edge
        step(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'hFF);
        // randomized traffic
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 8'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
